tick_scheduler: RTL and testbench

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_scheduler.sv | 151 +++++++++++++++
 tb/tb_tick_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// Base-tick prescaler with four periodic channels feeding a round-robin
// arbitrated single-entry event output (valid/ready).
module tick_scheduler #(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned TICK_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_ch,
  input  logic [15:0] cfg_period,
  input  logic [3:0]  ch_en,
  output logic        tick,
  output logic        evt_valid,
  output logic [1:0]  evt_ch,
  input  logic        evt_ready,
  output logic [3:0]  pend,
  output logic [3:0]  overrun
);

  localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned PW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned NCH  = 4;
  localparam int unsigned CW   = 16;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic                  tick_q;
  logic [NCH-1:0][CW-1:0] period_q, period_d;
  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]        pend_q, pend_d;
  logic [NCH-1:0]        ovr_q, ovr_d;
  logic                  valid_q, valid_d;
  logic [1:0]            ch_q, ch_d;
  logic [1:0]            lg_q, lg_d;
  logic [NCH-1:0]        fire_c;
  logic [NCH-1:0]        grant_c;
  logic                  load_c;
  logic [1:0]            sel_c;

  // Prescaler wraps at DIV-1; tick register mirrors "count == DIV-1".
  always_comb begin
    presc_d = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
  end

  // Per-channel period/counter update; a config write overrides any fire.
  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    fire_c   = '0;
    for (int c = 0; c < NCH; c++) begin
      if (cfg_we && (cfg_ch == 2'(c))) begin
        period_d[c] = cfg_period;
        cnt_d[c]    = (cfg_period == '0) ? '0 : cfg_period - CW'(1);
      end else if (!ch_en[c] || (period_q[c] == '0)) begin
        cnt_d[c] = (period_q[c] == '0) ? '0 : period_q[c] - CW'(1);
      end else if (tick_q) begin
        if (cnt_q[c] == '0) begin
          fire_c[c] = 1'b1;
          cnt_d[c]  = period_q[c] - CW'(1);
        end else begin
          cnt_d[c] = cnt_q[c] - CW'(1);
        end
      end
    end
  end

  // Round-robin pick of the first pending channel after the last grant.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found = 1'b0;
    idx   = '0;
    sel_c = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = lg_q + 2'(k);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        sel_c = idx;
      end
    end
  end

  // Output register load/drain and last-grant tracking.
  always_comb begin
    valid_d = valid_q;
    ch_d    = ch_q;
    lg_d    = lg_q;
    grant_c = '0;
    load_c  = (!valid_q || evt_ready) && (|pend_q);
    if (load_c) begin
      valid_d        = 1'b1;
      ch_d           = sel_c;
      lg_d           = sel_c;
      grant_c[sel_c] = 1'b1;
    end else if (valid_q && evt_ready) begin
      valid_d = 1'b0;
    end
  end

  // Pending/overrun bookkeeping; a grant frees the slot for a same-cycle fire.
  always_comb begin
    pend_d = pend_q & ~grant_c;
    ovr_d  = ovr_q;
    for (int c = 0; c < NCH; c++) begin
      if (fire_c[c]) begin
        if (pend_q[c] && !grant_c[c]) begin
          ovr_d[c] = 1'b1;
        end else begin
          pend_d[c] = 1'b1;
        end
      end
    end
    if (cfg_we) begin
      pend_d[cfg_ch] = 1'b0;
      ovr_d[cfg_ch]  = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      tick_q   <= 1'b0;
      period_q <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      ovr_q    <= '0;
      valid_q  <= 1'b0;
      ch_q     <= '0;
      lg_q     <= 2'd3;
    end else begin
      presc_q  <= presc_d;
      tick_q   <= (presc_d == PMAX);
      period_q <= period_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      valid_q  <= valid_d;
      ch_q     <= ch_d;
      lg_q     <= lg_d;
    end
  end

  assign tick      = tick_q;
  assign evt_valid = valid_q;
  assign evt_ch    = ch_q;
  assign pend      = pend_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler at DIV=10.
module tb_tick_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic [3:0]  ch_en;
  logic        tick;
  logic        evt_valid;
  logic [1:0]  evt_ch;
  logic        evt_ready;
  logic [3:0]  pend;
  logic [3:0]  overrun;

  int total = 0;
  int bad   = 0;

  tick_scheduler #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .ch_en      (ch_en),
    .tick       (tick),
    .evt_valid  (evt_valid),
    .evt_ch     (evt_ch),
    .evt_ready  (evt_ready),
    .pend       (pend),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to the next negedge at which tick is high (bounded).
  task automatic wait_tick;
    int n;
    n = 0;
    @(negedge clk);
    while (tick !== 1'b1 && n < 25) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) begin
      total++; bad++;
      $display("FAIL wait_tick: tick=%b required 1 within 25 cycles", tick);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
    ch_en = '0; evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] p);
    cfg_we = 1'b1; cfg_ch = ch; cfg_period = p;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
    ch_en = '0; evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL rst_tick: got %b want 0", tick); end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", evt_valid); end
    total++; if (evt_ch !== 2'd0) begin bad++; $display("FAIL rst_ch: got %0d want 0", evt_ch); end
    total++; if (pend !== 4'b0) begin bad++; $display("FAIL rst_pend: got %b want 0000", pend); end
    total++; if (overrun !== 4'b0) begin bad++; $display("FAIL rst_ovr: got %b want 0000", overrun); end
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      total++;
      if (tick !== ((k % 10) == 9)) begin
        bad++; $display("FAIL tick_period cyc%0d: got %b want %b", k + 1, tick, (k % 10) == 9);
      end
      total++;
      if (evt_valid !== 1'b0) begin bad++; $display("FAIL idle_valid cyc%0d: got %b want 0", k + 1, evt_valid); end
    end
  endtask

  task automatic test_single;
    logic exp;
    do_reset();
    evt_ready = 1'b1; ch_en = 4'b0001;
    cfg_write(2'd0, 16'd3);
    for (int n = 1; n <= 6; n++) begin
      exp = ((n % 3) == 0);
      wait_tick();
      @(negedge clk);
      total++; if (pend[0] !== exp) begin bad++; $display("FAIL single_pend t%0d: got %b want %b", n, pend[0], exp); end
      @(negedge clk);
      total++; if (evt_valid !== exp) begin bad++; $display("FAIL single_valid t%0d: got %b want %b", n, evt_valid, exp); end
      if (exp) begin
        total++; if (evt_ch !== 2'd0) begin bad++; $display("FAIL single_ch t%0d: got %0d want 0", n, evt_ch); end
      end
      @(negedge clk);
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_drop t%0d: got %b want 0", n, evt_valid); end
    end
  endtask

  task automatic test_round_robin;
    do_reset();
    evt_ready = 1'b0; ch_en = 4'b1111;
    for (int c = 0; c < 4; c++) cfg_write(2'(c), 16'd2);
    wait_tick();
    wait_tick();
    @(negedge clk);
    total++; if (pend !== 4'b1111) begin bad++; $display("FAIL rr_pend: got %b want 1111", pend); end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rr_empty: got %b want 0", evt_valid); end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL rr_valid%0d: got %b want 1", i, evt_valid); end
      total++; if (evt_ch !== 2'(i)) begin bad++; $display("FAIL rr_order%0d: got %0d want %0d", i, evt_ch, i); end
    end
    @(negedge clk);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rr_drain: got %b want 0", evt_valid); end
    total++; if (pend !== 4'b0) begin bad++; $display("FAIL rr_pend_clr: got %b want 0000", pend); end
  endtask

  task automatic test_overrun;
    do_reset();
    evt_ready = 1'b0; ch_en = 4'b0010;
    cfg_write(2'd1, 16'd1);
    wait_tick();
    @(negedge clk);
    total++; if (pend !== 4'b0010) begin bad++; $display("FAIL ovr_pend1: got %b want 0010", pend); end
    @(negedge clk);
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin bad++; $display("FAIL ovr_offer: got v=%b ch=%0d want v=1 ch=1", evt_valid, evt_ch); end
    total++; if (pend !== 4'b0) begin bad++; $display("FAIL ovr_taken: got %b want 0000", pend); end
    wait_tick();
    @(negedge clk);
    total++; if (pend !== 4'b0010 || overrun !== 4'b0) begin bad++; $display("FAIL ovr_second: got p=%b o=%b want p=0010 o=0000", pend, overrun); end
    wait_tick();
    @(negedge clk);
    total++; if (pend !== 4'b0010 || overrun !== 4'b0010) begin bad++; $display("FAIL ovr_third: got p=%b o=%b want p=0010 o=0010", pend, overrun); end
    ch_en = 4'b0000;
    cfg_write(2'd1, 16'd1);
    total++; if (pend !== 4'b0 || overrun !== 4'b0) begin bad++; $display("FAIL ovr_cfgclr: got p=%b o=%b want 0000/0000", pend, overrun); end
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin bad++; $display("FAIL ovr_keep: got v=%b ch=%0d want v=1 ch=1", evt_valid, evt_ch); end
    repeat (3) @(negedge clk);
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin bad++; $display("FAIL ovr_stable: got v=%b ch=%0d want v=1 ch=1", evt_valid, evt_ch); end
  endtask

  task automatic test_cfg_collision;
    logic exp;
    do_reset();
    evt_ready = 1'b1; ch_en = 4'b0100;
    cfg_write(2'd2, 16'd1);
    wait_tick();
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_period = 16'd3;
    @(negedge clk);
    cfg_we = 1'b0;
    total++; if (pend[2] !== 1'b0 || overrun[2] !== 1'b0) begin bad++; $display("FAIL coll_pend: got p=%b o=%b want 0/0", pend[2], overrun[2]); end
    @(negedge clk);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL coll_valid: got %b want 0", evt_valid); end
    for (int n = 1; n <= 3; n++) begin
      exp = (n == 3);
      wait_tick();
      @(negedge clk);
      total++; if (pend[2] !== exp) begin bad++; $display("FAIL coll_reload t%0d: got %b want %b", n, pend[2], exp); end
      @(negedge clk);
      total++; if (evt_valid !== exp) begin bad++; $display("FAIL coll_evt t%0d: got %b want %b", n, evt_valid, exp); end
      if (exp) begin
        total++; if (evt_ch !== 2'd2) begin bad++; $display("FAIL coll_ch: got %0d want 2", evt_ch); end
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    evt_ready = 1'b0; ch_en = 4'b1010;
    cfg_write(2'd1, 16'd1);
    cfg_write(2'd3, 16'd1);
    wait_tick();
    @(negedge clk);
    total++; if (pend !== 4'b1010) begin bad++; $display("FAIL mid_pendA: got %b want 1010", pend); end
    @(negedge clk);
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin bad++; $display("FAIL mid_offer: got v=%b ch=%0d want v=1 ch=1", evt_valid, evt_ch); end
    wait_tick();
    @(negedge clk);
    total++; if (pend !== 4'b1010 || overrun !== 4'b1000) begin bad++; $display("FAIL mid_pendB: got p=%b o=%b want p=1010 o=1000", pend, overrun); end
    rst_n = 1'b0; ch_en = 4'b0100;
    #1;
    total++; if (evt_valid !== 1'b0 || evt_ch !== 2'd0 || tick !== 1'b0) begin bad++; $display("FAIL mid_rst_out: got v=%b ch=%0d t=%b want 0/0/0", evt_valid, evt_ch, tick); end
    total++; if (pend !== 4'b0 || overrun !== 4'b0) begin bad++; $display("FAIL mid_rst_flags: got p=%b o=%b want 0000/0000", pend, overrun); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cfg_write(2'd2, 16'd1);
    total++; if (evt_valid !== 1'b0 || pend !== 4'b0) begin bad++; $display("FAIL mid_after: got v=%b p=%b want 0/0000", evt_valid, pend); end
    evt_ready = 1'b1;
    wait_tick();
    @(negedge clk);
    total++; if (pend !== 4'b0100) begin bad++; $display("FAIL mid_newpend: got %b want 0100", pend); end
    @(negedge clk);
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd2) begin bad++; $display("FAIL mid_newoffer: got v=%b ch=%0d want v=1 ch=2", evt_valid, evt_ch); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overrun();
    test_cfg_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
